// File: rtl/key_onehot_debounce.sv
// ============================================================================
// key_onehot_debounce
// ----------------------------------------------------------------------------
// Front end for the 4-to-2 key encoder. Four raw push buttons are brought into
// the clock domain through a two-flop synchronizer, debounced independently,
// and turned into a registered one-hot code with an enable. The enable is only
// asserted while exactly one debounced key is held, so the encoder downstream
// never sees an ambiguous multi-key code.
//
// Parameters
//   DB_CYCLES : consecutive stable cycles needed to accept a level change
//               (must be >= 2).
//   CNT_W     : debounce counter width, derived from DB_CYCLES.
//
// Ports
//   i_clk         in   1  sole clock, rising edge
//   i_rst         in   1  synchronous, active-high reset
//   i_key_in      in   4  raw buttons, asynchronous, active-high, may bounce
//   o_I           out  4  one-hot key code to the encoder (registered)
//   o_en          out  1  encoder enable, high while exactly one key is held
//   o_key_valid   out  1  one-cycle strobe for each newly accepted single key
//   o_multi_err   out  1  level, high while two or more keys are held
// ============================================================================
module key_onehot_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_in,
    output logic [3:0] o_I,
    output logic       o_en,
    output logic       o_key_valid,
    output logic       o_multi_err
);

    // Number of debounced keys currently held.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int b = 0; b < 4; b++) begin
            n = n + {2'b00, v[b]};
        end
        return n;
    endfunction

    // Terminal count: the cycle on which a persisting difference is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Synchronizer stages.
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;

    // Per-key debounce state.
    logic [3:0][CNT_W-1:0] r_cnt;
    logic [3:0]            r_db;

    // Output stage.
    logic [3:0]            r_prev_db;
    logic [3:0]            r_code;
    logic                  r_en;
    logic                  r_key_valid;
    logic                  r_multi_err;

    // Decoded view of the debounced vector.
    logic [2:0]            w_pop;
    logic                  w_single;
    logic                  w_multi;
    logic                  w_changed;

    // Two-flop synchronizer; the raw buttons are asynchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= i_key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce: count consecutive cycles of disagreement between the
    // synchronized input and the accepted level; any agreement restarts the
    // count, so a bounce shorter than DB_CYCLES never reaches the terminal
    // count. The counter clears on acceptance, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_db  <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_db[k]  <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Classify the debounced vector: idle, single key, or multiple keys, and
    // whether it differs from the previous cycle's value.
    always_comb begin
        w_pop     = 3'd0;
        w_single  = 1'b0;
        w_multi   = 1'b0;
        w_changed = 1'b0;
        w_pop     = popcount4(r_db);
        w_single  = (w_pop == 3'd1);
        w_multi   = (w_pop >= 3'd2);
        w_changed = (r_db != r_prev_db);
    end

    // Registered output stage. The implied state (idle / single / multi) is
    // popcount(r_db); no separate state register is needed. The code is only
    // loaded in the single-key state, so it holds the last key pressed while
    // idle and the last unique key while several are held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_db   <= 4'b0000;
            r_code      <= 4'b0000;
            r_en        <= 1'b0;
            r_key_valid <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_prev_db <= r_db;
            if (w_single) begin
                r_code <= r_db;
                r_en   <= 1'b1;
            end else begin
                r_code <= r_code;
                r_en   <= 1'b0;
            end
            // A strobe fires on entering single-key state from idle or multi,
            // and when one key swaps for another on the same edge.
            r_key_valid <= w_single & w_changed;
            r_multi_err <= w_multi;
        end
    end

    assign o_I         = r_code;
    assign o_en        = r_en;
    assign o_key_valid = r_key_valid;
    assign o_multi_err = r_multi_err;

    key_onehot_debounce_chk #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_chk (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cnt       (r_cnt),
        .i_code      (r_code),
        .i_en        (r_en),
        .i_key_valid (r_key_valid),
        .i_multi_err (r_multi_err)
    );

endmodule

// ============================================================================
// key_onehot_debounce_chk
// ----------------------------------------------------------------------------
// Property checker for key_onehot_debounce. Holds only assertions; it drives
// nothing.
//
// Ports
//   i_clk, i_rst   clock and synchronous reset of the checked block
//   i_cnt          per-key debounce counters
//   i_code         registered one-hot code
//   i_en           encoder enable
//   i_key_valid    new-press strobe
//   i_multi_err    multi-key level
// ============================================================================
module key_onehot_debounce_chk #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input logic                  i_clk,
    input logic                  i_rst,
    input logic [3:0][CNT_W-1:0] i_cnt,
    input logic [3:0]            i_code,
    input logic                  i_en,
    input logic                  i_key_valid,
    input logic                  i_multi_err
);

    // The strobe and the multi-key level are mutually exclusive.
    a_kv_vs_multi: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_key_valid && i_multi_err));

    // Whenever the encoder is enabled the code it sees is one-hot.
    a_en_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_en || $onehot(i_code)));

    // A strobe always coincides with an enabled, single-key output.
    a_kv_implies_en: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_key_valid || i_en));

    // Debounce counters stay within range and never wrap.
    for (genvar k = 0; k < 4; k++) begin : g_cnt
        a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
            (i_cnt[k] <= CNT_W'(DB_CYCLES - 1)));
    end

endmodule
